// File: rtl/alu_exec_unit.sv
// alu_exec_unit: 32-bit execute unit with a valid/ready handshake on input and output.
// Logic and arithmetic ops finish on the accept edge. SLL uses a serial shifter that
// moves one bit per cycle, so the unit needs no barrel shifter.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [2:0] SEL_AND  = 3'b000;
    localparam logic [2:0] SEL_OR   = 3'b001;
    localparam logic [2:0] SEL_ADD  = 3'b010;
    localparam logic [2:0] SEL_SLT  = 3'b011;
    localparam logic [2:0] SEL_ADDU = 3'b100;
    localparam logic [2:0] SEL_SLL  = 3'b101;
    localparam logic [2:0] SEL_SUB  = 3'b110;
    localparam logic [2:0] SEL_SLTU = 3'b111;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] acc;
    logic [4:0]       cnt;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] sum_s;
    logic signed [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_ovf;
    logic [WIDTH-1:0]        acc_shl;
    logic                    accept;
    logic                    is_sll;

    // Signed overflow on addition: same-sign operands give a result of the other sign.
    function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    // Signed overflow on subtraction: operands of opposite sign give a result whose sign differs from a.
    function automatic logic sub_ovf(input logic signed [WIDTH-1:0] a,
                                     input logic signed [WIDTH-1:0] b,
                                     input logic signed [WIDTH-1:0] r);
        return (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    endfunction

    assign a_s     = op_a;
    assign b_s     = op_b;
    assign sum_s   = a_s + b_s;
    assign diff_s  = a_s - b_s;
    assign acc_shl = {acc[WIDTH-2:0], 1'b0};

    // in_ready drops in the same cycle rst rises, so rst beats a simultaneous in_valid.
    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign is_sll    = (sel == SEL_SLL);

    // Single-cycle result and overflow flag for every op except the serial shift.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (sel)
            SEL_AND:  alu_res = op_a & op_b;
            SEL_OR:   alu_res = op_a | op_b;
            SEL_ADD: begin
                alu_res = sum_s;
                alu_ovf = add_ovf(a_s, b_s, sum_s);
            end
            SEL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            SEL_ADDU: alu_res = sum_s;
            SEL_SUB: begin
                alu_res = diff_s;
                alu_ovf = sub_ovf(a_s, b_s, diff_s);
            end
            SEL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            default:  alu_res = op_b;  // SLL by zero is a pass-through of op_b
        endcase
    end

    // Next-state logic: a nonzero SLL detours through SHIFT, and every other op goes straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_sll && (shamt != 5'd0)) begin
                        state_next = SHIFT;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            SHIFT: begin
                if (cnt == 5'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Result, flags and shifter registers. The result and flags change only when an op completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_sll && (shamt != 5'd0)) begin
                            acc <= op_b;
                            cnt <= shamt;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                            ovf    <= alu_ovf;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_shl;
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        result <= acc_shl;
                        zero   <= (acc_shl == '0);
                        ovf    <= 1'b0;
                    end
                end
                default: begin
                    // DONE holds the result until the consumer takes it.
                end
            endcase
        end
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle 32-bit execute unit that consumes the 3-bit ALU select code produced by the ALU control decode and returns the result with a valid/ready handshake on both sides. AND, OR, ADD, ADDU, SUB, SLT and SLTU complete in one cycle. SLL runs as a serial one-bit-per-cycle shifter so that no 32-bit barrel shifter is needed. The block sits between operand fetch and write-back in the processor datapath.

## Interface
- WIDTH, 32, datapath width. Only 32 is supported.
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands and sel are valid.
- in_ready  output  1  unit can accept; equals (state==IDLE) && !rst.
- sel  input  3  operation: 000 AND, 001 OR, 010 ADD, 011 SLT, 100 ADDU, 101 SLL, 110 SUB/SUBU/branch compare, 111 SLTU.
- op_a  input  32  first operand (rs).
- op_b  input  32  second operand (rt or immediate).
- shamt  input  5  shift amount; used only for SLL.
- out_valid  output  1  result, zero and ovf are valid.
- out_ready  input  1  consumer takes the result.
- result  output  32  registered result.
- zero  output  1  registered, (result==0).
- ovf  output  1  registered signed overflow flag for ADD or sel 110; 0 for every other op.

## Operation
- States:
  - IDLE: in_ready=1.
  - SHIFT: serial SLL in progress.
  - DONE: out_valid=1.
- Accept happens in IDLE when in_valid=1. Capture sel, op_a, op_b and shamt on that edge.
- Non-SLL accept: compute and register result, zero and ovf on the accept edge, then go to DONE.
  - AND: a&b. OR: a|b.
  - ADD and ADDU: a+b, mod 2^32.
  - sel 110: a-b, mod 2^32.
  - SLT: {31'b0, $signed(a)<$signed(b)}.
  - SLTU: {31'b0, a<b unsigned}.
- ovf:
  - ADD: a[31]==b[31] && result[31]!=a[31].
  - sel 110: a[31]!=b[31] && result[31]!=a[31].
  - ADDU, SLT, SLTU, AND, OR, SLL: 0.
  - The flag is informational only; the unit never traps.
- SLL with shamt==0: result=op_b, go directly to DONE.
- SLL with shamt>0: load acc=op_b and cnt=shamt, go to SHIFT.
  - Each SHIFT cycle: acc<<=1 (zero fill), cnt-=1.
  - On the edge where cnt==1: register result=acc<<1, update zero, set ovf=0, go to DONE.
- DONE: hold result, zero and ovf stable while out_ready=0. When out_ready=1, go to IDLE.
- in_ready=0 in SHIFT and DONE. in_valid is ignored outside IDLE.
- result, zero and ovf keep their last values after leaving DONE. They are meaningful only while out_valid=1.

## Timing
- Reset values: state IDLE, result 0, zero 0, ovf 0, out_valid 0, acc 0, cnt 0. in_ready=0 while rst=1, and 1 on the first cycle after rst drops.
- Latency from the accept edge to out_valid high:
  - 1 cycle for non-SLL ops and for SLL with shamt=0.
  - shamt cycles for SLL with shamt>0 (max 31).
- Throughput: at most one op every 2 cycles (accept, then DONE with out_ready=1). No accept occurs in the same cycle as a DONE handoff.
- A DONE handoff with out_ready=1 returns to IDLE. in_ready rises on the next cycle.
- rst mid-SHIFT or in DONE aborts the op; no out_valid pulse follows.
- rst and in_valid high in the same cycle: rst wins; nothing is accepted.
- Inputs are sampled only on the accept edge. Operand changes after accept do not affect the result.

## Test plan
- Reset, then ADD with a=0x7FFFFFFF, b=1 -> out_valid one cycle after accept; result 0x80000000, ovf=1, zero=0. Repeat with sel=ADDU -> same result, ovf=0.
- sel 110 with a=0x80000000, b=1 -> result 0x7FFFFFFF, ovf=1. Then a=b=0x1234 -> result 0, zero=1, ovf=0.
- SLT with a=0xFFFFFFFF, b=1 -> result 1. SLTU with the same operands -> result 0. AND and OR of 0xF0F0F0F0 with 0x0FF00FF0 -> 0x00F000F0 and 0xFFF0FFF0.
- SLL op_b=3, shamt=4 -> in_ready low, out_valid exactly 4 cycles after accept, result 0x30. SLL op_b=1, shamt=31 -> 0x80000000 after 31 cycles. SLL shamt=0, op_b=0xABCD -> 0xABCD after 1 cycle.
- Backpressure: hold out_ready=0 for 3 cycles in DONE -> result and flags stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next cycle, then the new op is accepted.
- Assert rst at SHIFT cycle 5 of an SLL with shamt=20 -> no out_valid ever; outputs at reset values. The next accepted ADD 2+3 -> 5.
